servo_source_arbiter: RTL and testbench
=======================================

Name: servo_source_arbiter

Overview:
Shares the three servo channels between three angle producers: the playback sequencer, the accelerometer angle path and the manual switch input.
- Grants ownership by fixed priority, with a hold window after each update.
- Clamps and slew-limits each channel toward the granted target.
- Drives the 8-bit signed angles that feed the angle-to-PWM conversion stage.

Parameters:
CLOCK_FREQ_HZ, 50000000, system clock frequency.
STEP_MS, 1, slew tick period in ms; STEP_TICKS = STEP_MS*CLOCK_FREQ_HZ/1000.
MAX_STEP, 2, maximum degrees a channel moves per slew tick (1..127).
HOLD_MS, 500, ownership hold after the owner's last accepted update; HOLD_TICKS = HOLD_MS*CLOCK_FREQ_HZ/1000.
ANGLE_LIMIT, 90, symmetric clamp in degrees (1..127).

Ports:
clk  in  1  system clock
rst_a_n  in  1  reset; synchronous, active-low
enable  in  1  high = arbitration, hold countdown and slew run; low = freeze
seq_valid  in  1  sequencer update strobe, 1 cycle
seq_angles  in  24  {servo3,servo2,servo1}, each 8-bit two's complement
acc_valid  in  1  accelerometer update strobe
acc_angles  in  24  same packing
man_valid  in  1  manual update strobe
man_angles  in  24  same packing
servo_angles  out  24  current slewed angles, same packing
owner  out  2  0=NONE, 1=SEQ, 2=ACC, 3=MAN
settled  out  1  high when every channel equals its target
step_tick  out  1  1-cycle pulse when a slew step is applied

Behaviour:
- Reset (rst_a_n low at a clk edge):
  - servo_angles=0, all targets=0, owner=NONE, hold and tick counters=0.
  - settled=1, step_tick=0.
  - Reset mid-slew or mid-hold aborts immediately.
- Arbitration, only when enable=1; state is owner (NONE or OWNED-by-code):
  - A strobe with valid=1 is eligible if its code >= owner.
  - Of the eligible strobes in one cycle, the highest code wins; the rest are dropped, not queued.
  - On accept at edge N: targets<=clamp(angles), owner<=code, hold<=HOLD_TICKS-1. All are visible after edge N.
  - A lower-priority strobe while owned is ignored.
  - The current owner re-strobing refreshes targets and hold.
- Hold countdown:
  - While owner!=NONE and enable=1, hold decrements once per cycle.
  - On the cycle hold==0 with no accept: owner<=NONE; targets are retained.
  - If an accept occurs in that same cycle, the accept wins.
- Clamp: values >ANGLE_LIMIT become ANGLE_LIMIT; values <-ANGLE_LIMIT become -ANGLE_LIMIT. -128 clamps to -90 at the default limit.
- Slew:
  - The tick counter counts 0..STEP_TICKS-1 while enable=1. step_tick=1 on the cycle after it wraps.
  - On a tick, per channel: diff = target - current, computed 9-bit signed (no overflow).
  - If |diff| <= MAX_STEP, current<=target; else current<=current ± MAX_STEP.
  - servo_angles change only on tick edges.
  - If a tick and an accept coincide, the tick uses the pre-accept target; the new target applies from the next tick.
- settled: combinational equality of all three current/target pairs.
- enable=0: no accepts, hold frozen, tick counter frozen, outputs held, owner retained.

Decomposition:
Shared package holds:
- source codes SRC_NONE/SEQ/ACC/MAN (2-bit);
- ANGLE_W=8 and the 24-bit packing slice helpers;
- a function converting ms to ticks.

One natural sub-module: servo_slew_channel, instantiated three times. Per channel it holds the target and current registers, clamp and step logic. Inputs: load, load_angle, tick. Outputs: angle, at_target.

Test Plan (CLOCK_FREQ_HZ=10000, STEP_MS=1 gives 10-cycle tick; HOLD_MS=5 gives 50 cycles; MAX_STEP=2):
1. Reset, then seq_valid with angles {30,-10,5} → owner=1, settled=0. After ticks: servo1 goes 2,4,5; servo2 goes -2..-10; servo3 reaches 30 after 15 ticks; settled=1.
2. While SEQ owns, acc_valid {0,0,60} → owner=2, servo1 target 60. A later seq_valid {1,1,1} is ignored while ACC holds.
3. seq_valid, acc_valid and man_valid in the same cycle → owner=3 with the man_angles targets; the other two are dropped.
4. After the ACC accept, no strobes for 50 cycles → owner=0 exactly 50 edges after the accept. Targets are unchanged; a subsequent seq_valid is accepted.
5. man_valid {-128,127,100} → targets {-90,90,90}; outputs never exceed ±90.
6. Deassert enable mid-slew for 37 cycles → servo_angles, owner and hold frozen. The strobe during freeze is ignored. Slew resumes with the tick phase preserved. Reset asserted mid-slew → all outputs 0 and owner=0 on the next edge.

Source files
------------

// File: rtl/servo_source_arbiter_pkg.sv
// Shared definitions for the servo source arbiter.
// Holds the source codes, the angle packing width and slice helper,
// the clamp helper used by each channel and the ms-to-ticks conversion.
package servo_source_arbiter_pkg;

  localparam int ANGLE_W = 8;
  localparam int NUM_CH  = 3;
  localparam int PACK_W  = ANGLE_W * NUM_CH;

  // Source codes double as priorities: a larger code wins.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_SEQ  = 2'd1,
    SRC_ACC  = 2'd2,
    SRC_MAN  = 2'd3
  } src_e;

  // Extract channel idx (0 = servo1) from a {servo3,servo2,servo1} word.
  function automatic logic [ANGLE_W-1:0] get_angle(input logic [PACK_W-1:0] packed_angles,
                                                   input int idx);
    return packed_angles[idx*ANGLE_W +: ANGLE_W];
  endfunction

  // Symmetric saturation of a two's complement angle to +/-limit.
  function automatic logic [ANGLE_W-1:0] clamp_angle(input logic [ANGLE_W-1:0] raw,
                                                     input logic [ANGLE_W-1:0] limit);
    logic signed [ANGLE_W-1:0] s_raw;
    logic signed [ANGLE_W-1:0] s_lim;
    s_raw = $signed(raw);
    s_lim = $signed(limit);
    if (s_raw > s_lim) begin
      return limit;
    end else if (s_raw < -s_lim) begin
      return -limit;
    end else begin
      return raw;
    end
  endfunction

  // Milliseconds to clock cycles; 64-bit product so 50 MHz * 500 ms fits.
  // Never returns less than one cycle so counters stay well formed.
  function automatic int ms_to_ticks(input int ms, input int clk_hz);
    longint unsigned prod;
    longint unsigned ticks;
    prod  = 64'(ms) * 64'(clk_hz);
    ticks = prod / 64'd1000;
    if (ticks < 64'd1) begin
      return 1;
    end else begin
      return int'(ticks);
    end
  endfunction

endpackage

// File: rtl/servo_source_arbiter_slew_channel.sv
// One servo channel: target register, current (slewed) angle register,
// clamp on load and bounded step toward the target on each slew tick.
// Ports: clk, rst_a_n (sync, active-low), load / load_angle (new raw target),
//        tick (apply one slew step), angle (current), at_target (angle == target).
module servo_slew_channel
  import servo_source_arbiter_pkg::*;
#(
  parameter int MAX_STEP    = 2,
  parameter int ANGLE_LIMIT = 90
) (
  input  logic               clk,
  input  logic               rst_a_n,
  input  logic               load,
  input  logic [ANGLE_W-1:0] load_angle,
  input  logic               tick,
  output logic [ANGLE_W-1:0] angle,
  output logic               at_target
);

  localparam logic [ANGLE_W-1:0] LIMIT_A = ANGLE_W'(ANGLE_LIMIT);
  localparam logic [ANGLE_W-1:0] STEP_A  = ANGLE_W'(MAX_STEP);
  localparam logic [ANGLE_W:0]   STEP_D  = (ANGLE_W+1)'(MAX_STEP);
  localparam logic [ANGLE_W:0]   ONE_D   = (ANGLE_W+1)'(1);

  logic [ANGLE_W-1:0] target_q, target_d;
  logic [ANGLE_W-1:0] cur_q, cur_d;
  logic [ANGLE_W:0]   diff;
  logic [ANGLE_W:0]   mag;

  // Next target and next current angle; the step always uses the registered
  // target, so a load coinciding with a tick only takes effect next tick.
  always_comb begin
    target_d = target_q;
    cur_d    = cur_q;
    // Sign-extended 9-bit difference cannot overflow for 8-bit operands.
    diff = {target_q[ANGLE_W-1], target_q} - {cur_q[ANGLE_W-1], cur_q};
    mag  = diff[ANGLE_W] ? (~diff + ONE_D) : diff;
    if (tick) begin
      if (mag <= STEP_D) begin
        cur_d = target_q;
      end else if (diff[ANGLE_W]) begin
        cur_d = cur_q - STEP_A;
      end else begin
        cur_d = cur_q + STEP_A;
      end
    end else begin
      cur_d = cur_q;
    end
    if (load) begin
      target_d = clamp_angle(load_angle, LIMIT_A);
    end else begin
      target_d = target_q;
    end
  end

  // Channel state registers with synchronous reset to zero.
  always_ff @(posedge clk) begin
    if (!rst_a_n) begin
      target_q <= {ANGLE_W{1'b0}};
      cur_q    <= {ANGLE_W{1'b0}};
    end else begin
      target_q <= target_d;
      cur_q    <= cur_d;
    end
  end

  assign angle     = cur_q;
  assign at_target = (cur_q == target_q);

endmodule

// File: rtl/servo_source_arbiter.sv
// Shares three servo channels between the sequencer (SEQ), accelerometer
// path (ACC) and manual switches (MAN). Fixed priority MAN > ACC > SEQ with
// an ownership hold window after each accepted update; each channel is
// clamped and slew-limited toward the granted target.
// Ports: clk, rst_a_n (sync, active-low), enable (low freezes everything),
//        {seq,acc,man}_valid/_angles (update strobes, {servo3,servo2,servo1}),
//        servo_angles (slewed output), owner (0 none,1 seq,2 acc,3 man),
//        settled (all channels at target), step_tick (slew step applied).
module servo_source_arbiter
  import servo_source_arbiter_pkg::*;
#(
  parameter int CLOCK_FREQ_HZ = 50000000,
  parameter int STEP_MS       = 1,
  parameter int MAX_STEP      = 2,
  parameter int HOLD_MS       = 500,
  parameter int ANGLE_LIMIT   = 90
) (
  input  logic              clk,
  input  logic              rst_a_n,
  input  logic              enable,
  input  logic              seq_valid,
  input  logic [PACK_W-1:0] seq_angles,
  input  logic              acc_valid,
  input  logic [PACK_W-1:0] acc_angles,
  input  logic              man_valid,
  input  logic [PACK_W-1:0] man_angles,
  output logic [PACK_W-1:0] servo_angles,
  output logic [1:0]        owner,
  output logic              settled,
  output logic              step_tick
);

  localparam int STEP_TICKS = ms_to_ticks(STEP_MS, CLOCK_FREQ_HZ);
  localparam int HOLD_TICKS = ms_to_ticks(HOLD_MS, CLOCK_FREQ_HZ);
  localparam int TICK_W     = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int HOLD_W     = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [TICK_W-1:0] STEP_LAST = TICK_W'(STEP_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  src_e              owner_q, owner_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              step_tick_q, step_tick_d;

  src_e              cand_src;
  logic              accept;
  logic              wrap;
  logic [PACK_W-1:0] load_angles;
  logic [ANGLE_W-1:0] ch_angle [NUM_CH];
  logic [NUM_CH-1:0] ch_at_target;

  // Priority pick among strobes whose code is not below the current owner.
  always_comb begin
    cand_src = SRC_NONE;
    if (man_valid && (SRC_MAN >= owner_q)) begin
      cand_src = SRC_MAN;
    end else if (acc_valid && (SRC_ACC >= owner_q)) begin
      cand_src = SRC_ACC;
    end else if (seq_valid && (SRC_SEQ >= owner_q)) begin
      cand_src = SRC_SEQ;
    end else begin
      cand_src = SRC_NONE;
    end
  end

  assign accept = enable && (cand_src != SRC_NONE);

  // Route the winning source's angles to the channel load inputs.
  always_comb begin
    load_angles = {PACK_W{1'b0}};
    case (cand_src)
      SRC_SEQ: load_angles = seq_angles;
      SRC_ACC: load_angles = acc_angles;
      SRC_MAN: load_angles = man_angles;
      default: load_angles = {PACK_W{1'b0}};
    endcase
  end

  // Ownership and hold countdown; an accept on the expiry cycle wins.
  always_comb begin
    owner_d = owner_q;
    hold_d  = hold_q;
    if (!enable) begin
      owner_d = owner_q;
      hold_d  = hold_q;
    end else if (accept) begin
      owner_d = cand_src;
      hold_d  = HOLD_LAST;
    end else if (owner_q != SRC_NONE) begin
      if (hold_q == {HOLD_W{1'b0}}) begin
        owner_d = SRC_NONE;
      end else begin
        hold_d = hold_q - HOLD_W'(1);
      end
    end else begin
      owner_d = owner_q;
    end
  end

  // Free-running slew tick divider; frozen while disabled so phase survives.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    wrap       = 1'b0;
    if (enable) begin
      if (tick_cnt_q == STEP_LAST) begin
        tick_cnt_d = {TICK_W{1'b0}};
        wrap       = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + TICK_W'(1);
      end
    end else begin
      tick_cnt_d = tick_cnt_q;
    end
    step_tick_d = wrap;
  end

  // Arbiter and divider state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_a_n) begin
      owner_q     <= SRC_NONE;
      hold_q      <= {HOLD_W{1'b0}};
      tick_cnt_q  <= {TICK_W{1'b0}};
      step_tick_q <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      hold_q      <= hold_d;
      tick_cnt_q  <= tick_cnt_d;
      step_tick_q <= step_tick_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    servo_slew_channel #(
      .MAX_STEP   (MAX_STEP),
      .ANGLE_LIMIT(ANGLE_LIMIT)
    ) u_ch (
      .clk       (clk),
      .rst_a_n   (rst_a_n),
      .load      (accept),
      .load_angle(get_angle(load_angles, i)),
      .tick      (wrap),
      .angle     (ch_angle[i]),
      .at_target (ch_at_target[i])
    );
    assign servo_angles[i*ANGLE_W +: ANGLE_W] = ch_angle[i];
  end

  assign owner     = owner_q;
  assign settled   = &ch_at_target;
  assign step_tick = step_tick_q;

endmodule

// File: tb/tb_servo_source_arbiter.sv
module tb_servo_source_arbiter;

  logic        clk = 1'b0;
  logic        rst_a_n;
  logic        enable;
  logic        seq_valid, acc_valid, man_valid;
  logic [23:0] seq_angles, acc_angles, man_angles;
  logic [23:0] servo_angles;
  logic [1:0]  owner;
  logic        settled;
  logic        step_tick;

  always #5 clk = ~clk;

  servo_source_arbiter #(
    .CLOCK_FREQ_HZ(10000),
    .STEP_MS      (1),
    .MAX_STEP     (2),
    .HOLD_MS      (5),
    .ANGLE_LIMIT  (90)
  ) dut (
    .clk         (clk),
    .rst_a_n     (rst_a_n),
    .enable      (enable),
    .seq_valid   (seq_valid),
    .seq_angles  (seq_angles),
    .acc_valid   (acc_valid),
    .acc_angles  (acc_angles),
    .man_valid   (man_valid),
    .man_angles  (man_angles),
    .servo_angles(servo_angles),
    .owner       (owner),
    .settled     (settled),
    .step_tick   (step_tick)
  );

  typedef struct {
    int          tag;
    logic [1:0]  owner;
    logic        settled;
    logic        tick;
    logic        chk_ang;
    logic [23:0] ang;
  } probe_t;

  probe_t      probe_q[$];
  logic [23:0] tick_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_probes = 0;
  int n_ticks  = 0;

  function automatic logic [23:0] pk(input int s3, input int s2, input int s1);
    logic [7:0] a3, a2, a1;
    a3 = 8'(s3); a2 = 8'(s2); a1 = 8'(s1);
    return {a3, a2, a1};
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Monitor: probes are checked just after the edge following their push;
  // tick expectations are popped whenever the DUT pulses step_tick.
  initial begin
    probe_t p;
    logic [23:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (probe_q.size() > 0) begin
        p = probe_q.pop_front();
        n_checks++;
        if (owner !== p.owner || settled !== p.settled || step_tick !== p.tick ||
            (p.chk_ang && servo_angles !== p.ang)) begin
          n_fail++;
          $display("FAIL probe_%0d: got owner=%0d settled=%0b step_tick=%0b angles=%h, expected owner=%0d settled=%0b step_tick=%0b angles=%h (angles checked=%0b)",
                   p.tag, owner, settled, step_tick, servo_angles,
                   p.owner, p.settled, p.tick, p.ang, p.chk_ang);
        end
      end
      if (step_tick === 1'b1 && tick_q.size() > 0) begin
        e = tick_q.pop_front();
        n_checks++;
        if (servo_angles !== e) begin
          n_fail++;
          $display("FAIL tick_%0d: got angles=%h, expected %h", n_ticks, servo_angles, e);
        end
        n_ticks++;
      end
    end
  end

  task automatic push_probe(input logic [1:0] o, input logic s, input logic t,
                            input logic ca, input logic [23:0] a);
    probe_t p;
    p.tag = n_probes; p.owner = o; p.settled = s; p.tick = t; p.chk_ang = ca; p.ang = a;
    n_probes++;
    probe_q.push_back(p);
  endtask

  // Drive strobes for one cycle; expectation describes state after that edge.
  task automatic strobe(input logic sv, input logic av, input logic mv,
                        input logic [23:0] sa, input logic [23:0] aa, input logic [23:0] ma,
                        input logic [1:0] eo, input logic es, input logic [23:0] ea);
    seq_valid = sv; acc_valid = av; man_valid = mv;
    seq_angles = sa; acc_angles = aa; man_angles = ma;
    push_probe(eo, es, 1'b0, 1'b1, ea);
    @(negedge clk);
    seq_valid = 1'b0; acc_valid = 1'b0; man_valid = 1'b0;
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (step_tick === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wait_tick: got no step_tick within 40 cycles, expected one");
    end
  endtask

  task automatic wait_drain(input int max_cyc);
    int i;
    i = 0;
    while (tick_q.size() > 0 && i < max_cyc) begin
      @(negedge clk);
      i++;
    end
    n_checks++;
    if (tick_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d tick expectations left after %0d cycles, expected 0",
               tick_q.size(), max_cyc);
      tick_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a_n = 1'b0; enable = 1'b1;
    seq_valid = 1'b0; acc_valid = 1'b0; man_valid = 1'b0;
    seq_angles = 24'h0; acc_angles = 24'h0; man_angles = 24'h0;
    repeat (2) @(negedge clk);
    push_probe(2'd0, 1'b1, 1'b0, 1'b1, pk(0, 0, 0));
    @(negedge clk);
    rst_a_n = 1'b1;

    // 1: SEQ update from idle, slew to {30,-10,5}
    wait_tick();
    strobe(1'b1, 1'b0, 1'b0, pk(30, -10, 5), 24'h0, 24'h0, 2'd1, 1'b0, pk(0, 0, 0));
    for (int k = 1; k <= 15; k++)
      tick_q.push_back(pk(imin(2*k, 30), imax(-2*k, -10), imin(2*k, 5)));
    wait_drain(200);
    push_probe(2'd0, 1'b1, 1'b0, 1'b1, pk(30, -10, 5));

    // 2: ACC preempts SEQ, SEQ ignored while ACC holds; 4: hold expiry at 50 edges
    wait_tick();
    strobe(1'b1, 1'b0, 1'b0, pk(30, -10, 5), 24'h0, 24'h0, 2'd1, 1'b1, pk(30, -10, 5));
    strobe(1'b0, 1'b1, 1'b0, 24'h0, pk(0, 0, 60), 24'h0, 2'd2, 1'b0, pk(30, -10, 5));
    strobe(1'b1, 1'b0, 1'b0, pk(1, 1, 1), 24'h0, 24'h0, 2'd2, 1'b0, pk(30, -10, 5));
    for (int k = 1; k <= 28; k++)
      tick_q.push_back(pk(imax(30 - 2*k, 0), imin(-10 + 2*k, 0), imin(5 + 2*k, 60)));
    repeat (47) @(negedge clk);
    push_probe(2'd2, 1'b0, 1'b0, 1'b0, 24'h0);
    @(negedge clk);
    push_probe(2'd0, 1'b0, 1'b0, 1'b0, 24'h0);
    wait_drain(400);
    push_probe(2'd0, 1'b1, 1'b0, 1'b1, pk(0, 0, 60));

    wait_tick();
    strobe(1'b1, 1'b0, 1'b0, pk(3, 0, 60), 24'h0, 24'h0, 2'd1, 1'b0, pk(0, 0, 60));
    tick_q.push_back(pk(2, 0, 60));
    tick_q.push_back(pk(3, 0, 60));
    wait_drain(40);
    push_probe(2'd1, 1'b1, 1'b0, 1'b1, pk(3, 0, 60));

    // 3: all three strobes together, MAN wins
    wait_tick();
    strobe(1'b1, 1'b1, 1'b1, pk(10, 10, 10), pk(20, 20, 20), pk(-20, 40, 80),
           2'd3, 1'b0, pk(3, 0, 60));
    for (int k = 1; k <= 20; k++)
      tick_q.push_back(pk(imax(3 - 2*k, -20), imin(2*k, 40), imin(60 + 2*k, 80)));
    wait_drain(300);
    push_probe(2'd0, 1'b1, 1'b0, 1'b1, pk(-20, 40, 80));

    // 5: clamp of extreme values
    wait_tick();
    strobe(1'b0, 1'b0, 1'b1, 24'h0, 24'h0, pk(-128, 127, 100), 2'd3, 1'b0, pk(-20, 40, 80));
    for (int k = 1; k <= 35; k++)
      tick_q.push_back(pk(imax(-20 - 2*k, -90), imin(40 + 2*k, 90), imin(80 + 2*k, 90)));
    wait_drain(450);
    push_probe(2'd0, 1'b1, 1'b0, 1'b1, pk(-90, 90, 90));

    // 6: freeze for 37 cycles mid-slew, tick phase preserved, then reset
    wait_tick();
    strobe(1'b1, 1'b0, 1'b0, pk(0, 0, 0), 24'h0, 24'h0, 2'd1, 1'b0, pk(-90, 90, 90));
    repeat (3) @(negedge clk);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    strobe(1'b0, 1'b0, 1'b1, 24'h0, 24'h0, pk(5, 5, 5), 2'd1, 1'b0, pk(-90, 90, 90));
    repeat (26) @(negedge clk);
    enable = 1'b1;
    push_probe(2'd1, 1'b0, 1'b0, 1'b1, pk(-90, 90, 90));
    repeat (4) @(negedge clk);
    push_probe(2'd1, 1'b0, 1'b0, 1'b1, pk(-90, 90, 90));
    @(negedge clk);
    push_probe(2'd1, 1'b0, 1'b1, 1'b1, pk(-88, 88, 88));
    @(negedge clk);
    rst_a_n = 1'b0;
    push_probe(2'd0, 1'b1, 1'b0, 1'b1, pk(0, 0, 0));
    @(negedge clk);
    rst_a_n = 1'b1;
    repeat (8) @(negedge clk);
    push_probe(2'd0, 1'b1, 1'b0, 1'b1, pk(0, 0, 0));
    @(negedge clk);
    push_probe(2'd0, 1'b1, 1'b1, 1'b1, pk(0, 0, 0));
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
